// File: rtl/graph_csr_fetch.sv
// CSR neighbor fetcher: reads row_ptr[v] and row_ptr[v+1], then streams col_idx[start..end-1]
// into a first-word-fall-through output FIFO, issuing reads only against free FIFO credit.
module graph_csr_fetch #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MEM_LAT     = 2,
    parameter int unsigned ROWPTR_BASE = 0,
    parameter int unsigned COLIDX_BASE = 'h4000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] v_id_in,
    input  logic              v_valid_in,
    output logic              v_ready_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] rowidx_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    input  logic              data_ready_in,
    output logic              last_out,
    output logic              empty_out,
    output logic              err_out
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [2:0] {
        StIdle, StRpLo, StRpHi, StRpWait, StStream, StFlush
    } state_e;

    typedef enum logic [1:0] {KindNone, KindLo, KindHi, KindCol} kind_e;

    state_e            state_q;
    logic              ready_q;
    logic              req_q;
    kind_e             req_kind_q;
    logic              req_last_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [DATA_W-1:0] v_q;
    logic [DATA_W-1:0] start_q;
    logic [DATA_W-1:0] end_q;
    logic [DATA_W-1:0] k_q;

    kind_e             kind_pipe_q [MEM_LAT];
    logic              last_pipe_q [MEM_LAT];
    logic [CNT_W-1:0]  inflight_q;

    logic [DATA_W-1:0] fifo_data_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_row_q   [FIFO_DEPTH];
    logic              fifo_last_q  [FIFO_DEPTH];
    logic              fifo_empty_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    kind_e             ret_kind;
    logic              ret_col;
    logic              credit;
    logic              accept;
    logic              zero_deg;
    logic              malformed;
    logic              empty_push;
    logic              issue_col;
    logic              col_last;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              push_last;
    logic              push_empty;

    // The pipe tail carries the tag of whatever read was on the bus MEM_LAT cycles ago.
    assign ret_kind   = kind_pipe_q[MEM_LAT-1];
    assign ret_col    = (ret_kind == KindCol);
    assign credit     = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
    assign accept     = (state_q == StIdle) && ready_q && v_valid_in;
    assign malformed  = (end_q < start_q);
    assign zero_deg   = (end_q <= start_q);
    assign empty_push = (state_q == StStream) && zero_deg && credit && (inflight_q == '0);
    assign issue_col  = (state_q == StStream) && !zero_deg && credit;
    assign col_last   = (k_q == end_q - DATA_W'(1));

    assign push       = ret_col || empty_push;
    assign pop        = data_valid_out && data_ready_in;
    assign push_data  = ret_col ? mem_data_in : '0;
    assign push_last  = ret_col ? last_pipe_q[MEM_LAT-1] : 1'b1;
    assign push_empty = !ret_col;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            req_kind_q <= KindNone;
            req_last_q <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            v_q        <= '0;
            start_q    <= '0;
            end_q      <= '0;
            k_q        <= '0;
        end else begin
            req_q      <= 1'b0;
            req_kind_q <= KindNone;
            req_last_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q    <= 1'b0;
                        v_q        <= v_id_in;
                        req_q      <= 1'b1;
                        req_kind_q <= KindLo;
                        addr_q     <= ADDR_W'(ROWPTR_BASE) + ADDR_W'(v_id_in);
                        state_q    <= StRpLo;
                    end
                end
                StRpLo: begin
                    req_q      <= 1'b1;
                    req_kind_q <= KindHi;
                    addr_q     <= addr_q + ADDR_W'(1);
                    state_q    <= StRpHi;
                end
                StRpHi: begin
                    state_q <= StRpWait;
                end
                StRpWait: begin
                    if (ret_kind == KindHi) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (empty_push) begin
                        err_q   <= err_q | malformed;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (issue_col) begin
                        req_q      <= 1'b1;
                        req_kind_q <= KindCol;
                        req_last_q <= col_last;
                        addr_q     <= ADDR_W'(COLIDX_BASE) + ADDR_W'(k_q);
                        k_q        <= k_q + DATA_W'(1);
                        if (col_last) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (inflight_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (ret_kind == KindLo) begin
                start_q <= mem_data_in;
                k_q     <= mem_data_in;
            end
            if (ret_kind == KindHi) begin
                end_q <= mem_data_in;
            end
        end
    end

    // Return-path tracking; clearing it on reset drops data for pre-reset reads.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                kind_pipe_q[i] <= KindNone;
                last_pipe_q[i] <= 1'b0;
            end
            inflight_q <= '0;
        end else begin
            kind_pipe_q[0] <= req_kind_q;
            last_pipe_q[0] <= req_last_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                kind_pipe_q[i] <= kind_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
            if (issue_col && !ret_col) begin
                inflight_q <= inflight_q + CNT_W'(1);
            end else if (!issue_col && ret_col) begin
                inflight_q <= inflight_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_row_q[i]   <= '0;
                fifo_last_q[i]  <= 1'b0;
                fifo_empty_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q]  <= push_data;
                fifo_row_q[wr_ptr_q]   <= v_q;
                fifo_last_q[wr_ptr_q]  <= push_last;
                fifo_empty_q[wr_ptr_q] <= push_empty;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign v_ready_out    = ready_q;
    assign mem_req_out    = req_q;
    assign mem_addr_out   = addr_q;
    assign err_out        = err_q;
    assign data_valid_out = (count_q != '0);
    assign data_out       = fifo_data_q[rd_ptr_q];
    assign rowidx_out     = fifo_row_q[rd_ptr_q];
    assign last_out       = fifo_last_q[rd_ptr_q];
    assign empty_out      = fifo_empty_q[rd_ptr_q];

endmodule

// File: tb/tb_graph_csr_fetch.sv
// Directed bench for graph_csr_fetch with a fixed-latency memory model and a beat monitor.
module tb_graph_csr_fetch;
    localparam int unsigned MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] v_id_in = '0;
    logic        v_valid_in = 1'b0;
    logic        v_ready_out;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic [31:0] mem_data_in;
    logic [31:0] rowidx_out;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        data_ready_in = 1'b1;
    logic        last_out;
    logic        empty_out;
    logic        err_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int col_reads = 0;
    int consumed = 0;
    int max_out = 0;
    int ready_mode = 0;

    logic [31:0] q_data [$];
    logic [31:0] q_row [$];
    logic        q_last [$];
    logic        q_empty [$];
    int          q_cyc [$];

    logic [31:0] mem [0:65535];
    logic [31:0] rd_pipe [MEM_LAT];

    graph_csr_fetch #(
        .DATA_W     (32),
        .ADDR_W     (16),
        .FIFO_DEPTH (4),
        .MEM_LAT    (MEM_LAT),
        .ROWPTR_BASE(0),
        .COLIDX_BASE('h4000)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .v_id_in       (v_id_in),
        .v_valid_in    (v_valid_in),
        .v_ready_out   (v_ready_out),
        .mem_req_out   (mem_req_out),
        .mem_addr_out  (mem_addr_out),
        .mem_data_in   (mem_data_in),
        .rowidx_out    (rowidx_out),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .data_ready_in (data_ready_in),
        .last_out      (last_out),
        .empty_out     (empty_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory is not reset, so reads issued before a reset still come back afterwards.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_req_out ? mem[mem_addr_out] : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_in = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       data_ready_in = 1'b1;
            1:       data_ready_in = (cyc % 3 == 0);
            default: data_ready_in = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (mem_req_out && mem_addr_out >= 16'h4000 && mem_addr_out < 16'h8000)
            col_reads = col_reads + 1;
        if (col_reads - consumed > max_out) max_out = col_reads - consumed;
        if (data_valid_out && data_ready_in) begin
            q_data.push_back(data_out);
            q_row.push_back(rowidx_out);
            q_last.push_back(last_out);
            q_empty.push_back(empty_out);
            q_cyc.push_back(cyc);
            consumed = consumed + 1;
        end
    end

    task automatic clear_obs();
        q_data.delete();
        q_row.delete();
        q_last.delete();
        q_empty.delete();
        q_cyc.delete();
        col_reads = 0;
        consumed = 0;
        max_out = 0;
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (!v_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!v_ready_out) begin
            total++;
            bad++;
            $display("FAIL send_ready_timeout: v_ready_out=%0b want 1", v_ready_out);
        end
        v_id_in = v;
        v_valid_in = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        v_valid_in = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (8) @(posedge clk);
        total++;
        if (q_data.size() != n) begin
            bad++;
            $display("FAIL %s_beat_count: got %0d want %0d", name, q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (v_ready_out !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %0b want 0", v_ready_out);
        end
        total++;
        if (data_valid_out !== 1'b0 || mem_req_out !== 1'b0 || err_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b req=%0b err=%0b want 0 0 0",
                     data_valid_out, mem_req_out, err_out);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (v_ready_out !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %0b want 1", v_ready_out);
        end
    endtask

    // Vertex 5: degree 3, beats 7,9,4 at cycles 8,9,10 after accept.
    task automatic run_vertex5(input string name);
        logic [31:0] exp_d [3];
        exp_d = '{32'd7, 32'd9, 32'd4};
        mem[5] = 32'd10;
        mem[6] = 32'd13;
        mem[16'h4000 + 10] = 32'd7;
        mem[16'h4000 + 11] = 32'd9;
        mem[16'h4000 + 12] = 32'd4;
        clear_obs();
        ready_mode = 0;
        send(32'd5);
        wait_beats(3, 60, name);
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            total++;
            if (q_data[i] !== exp_d[i] || q_row[i] !== 32'd5 || q_empty[i] !== 1'b0 ||
                q_last[i] !== (i == 2)) begin
                bad++;
                $display("FAIL %s_beat%0d: data=%0d row=%0d last=%0b empty=%0b want %0d 5 %0b 0",
                         name, i, q_data[i], q_row[i], q_last[i], q_empty[i], exp_d[i], i == 2);
            end
            total++;
            if (q_cyc[i] - acc_cyc != 8 + i) begin
                bad++;
                $display("FAIL %s_cycle%0d: got %0d want %0d", name, i, q_cyc[i] - acc_cyc, 8 + i);
            end
        end
        total++;
        if (col_reads != 3) begin
            bad++; $display("FAIL %s_col_reads: got %0d want 3", name, col_reads);
        end
    endtask

    task automatic test_basic();
        run_vertex5("basic");
    endtask

    task automatic test_zero_degree();
        mem[3] = 32'd20;
        mem[4] = 32'd20;
        clear_obs();
        send(32'd3);
        wait_beats(1, 60, "zero");
        if (q_data.size() >= 1) begin
            total++;
            if (q_data[0] !== 32'd0 || q_empty[0] !== 1'b1 || q_last[0] !== 1'b1 ||
                q_row[0] !== 32'd3) begin
                bad++;
                $display("FAIL zero_beat: data=%0d empty=%0b last=%0b row=%0d want 0 1 1 3",
                         q_data[0], q_empty[0], q_last[0], q_row[0]);
            end
        end
        total++;
        if (col_reads != 0 || err_out !== 1'b0) begin
            bad++;
            $display("FAIL zero_side: col_reads=%0d err=%0b want 0 0", col_reads, err_out);
        end
    endtask

    // Row pointer addresses 0xFFFF and 0x0000; ID bits above ADDR_W stay on rowidx.
    task automatic test_wrap();
        mem[16'hFFFF] = 32'd40;
        mem[0] = 32'd42;
        mem[16'h4000 + 40] = 32'd77;
        mem[16'h4000 + 41] = 32'd78;
        clear_obs();
        send(32'h0001_FFFF);
        wait_beats(2, 60, "wrap");
        for (int i = 0; i < 2 && i < q_data.size(); i++) begin
            total++;
            if (q_data[i] !== 32'd77 + 32'(i) || q_row[i] !== 32'h0001_FFFF ||
                q_last[i] !== (i == 1)) begin
                bad++;
                $display("FAIL wrap_beat%0d: data=%0d row=%0h last=%0b want %0d 1ffff %0b",
                         i, q_data[i], q_row[i], q_last[i], 77 + i, i == 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [5];
        logic        exp_l [5];
        exp_r = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd2};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        mem[1] = 32'd30;
        mem[2] = 32'd32;
        mem[3] = 32'd35;
        for (int i = 0; i < 5; i++) mem[16'h4000 + 30 + i] = 32'd50 + 32'(i);
        clear_obs();
        send(32'd1);
        send(32'd2);
        wait_beats(5, 100, "b2b");
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            total++;
            if (q_data[i] !== 32'd50 + 32'(i) || q_row[i] !== exp_r[i] ||
                q_last[i] !== exp_l[i] || q_empty[i] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_beat%0d: data=%0d row=%0d last=%0b want %0d %0d %0b",
                         i, q_data[i], q_row[i], q_last[i], 50 + i, exp_r[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        mem[7] = 32'd100;
        mem[8] = 32'd110;
        for (int i = 0; i < 10; i++) mem[16'h4000 + 100 + i] = 32'h100 + 32'(i);
        clear_obs();
        ready_mode = 1;
        send(32'd7);
        wait_beats(10, 400, "bp");
        ready_mode = 0;
        for (int i = 0; i < 10 && i < q_data.size(); i++) begin
            total++;
            if (q_data[i] !== 32'h100 + 32'(i) || q_row[i] !== 32'd7 || q_last[i] !== (i == 9)) begin
                bad++;
                $display("FAIL bp_beat%0d: data=%0h row=%0d last=%0b want %0h 7 %0b",
                         i, q_data[i], q_row[i], q_last[i], 32'h100 + i, i == 9);
            end
        end
        total++;
        if (max_out > 4) begin
            bad++; $display("FAIL bp_credit: outstanding=%0d want <=4", max_out);
        end
        total++;
        if (col_reads != 10) begin
            bad++; $display("FAIL bp_col_reads: got %0d want 10", col_reads);
        end
    endtask

    task automatic test_malformed();
        mem[2] = 32'd9;
        mem[3] = 32'd4;
        clear_obs();
        send(32'd2);
        wait_beats(1, 60, "malformed");
        if (q_data.size() >= 1) begin
            total++;
            if (q_empty[0] !== 1'b1 || q_last[0] !== 1'b1 || q_data[0] !== 32'd0) begin
                bad++;
                $display("FAIL malformed_beat: empty=%0b last=%0b data=%0d want 1 1 0",
                         q_empty[0], q_last[0], q_data[0]);
            end
        end
        total++;
        if (err_out !== 1'b1 || col_reads != 0) begin
            bad++;
            $display("FAIL malformed_err: err=%0b col_reads=%0d want 1 0", err_out, col_reads);
        end
        run_vertex5("after_err");
        total++;
        if (err_out !== 1'b1) begin
            bad++; $display("FAIL err_sticky: got %0b want 1", err_out);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_obs();
        ready_mode = 2;
        send(32'd7);
        while (col_reads < 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #2;
        total++;
        if (data_valid_out !== 1'b1 || mem_req_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: valid=%0b req=%0b want 1 1", data_valid_out, mem_req_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (data_valid_out !== 1'b0 || mem_req_out !== 1'b0 || v_ready_out !== 1'b0 ||
            err_out !== 1'b0 || data_out !== 32'd0 || rowidx_out !== 32'd0) begin
            bad++;
            $display("FAIL mid_zeroed: valid=%0b req=%0b rdy=%0b err=%0b data=%0h row=%0h want 0",
                     data_valid_out, mem_req_out, v_ready_out, err_out, data_out, rowidx_out);
        end
        repeat (3) @(negedge clk);
        ready_mode = 0;
        clear_obs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (v_ready_out !== 1'b1) begin
            bad++; $display("FAIL mid_release_ready: got %0b want 1", v_ready_out);
        end
        repeat (10) @(posedge clk);
        total++;
        if (q_data.size() != 0 || col_reads != 0) begin
            bad++;
            $display("FAIL mid_stale: beats=%0d col_reads=%0d want 0 0", q_data.size(), col_reads);
        end
        run_vertex5("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        test_reset();
        test_basic();
        test_zero_degree();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_malformed();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
